// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch stage: scalar/address aliases, the fetch->decode
// payload and the fetch controller state encoding.
package fetch_ctrl_pkg;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;
  typedef logic        u1;
  typedef u64          addr_t;

  // Architectural PC of the first fetch after reset.
  localparam addr_t PC_RESET = 64'h8000_0000;

  // Word handed to the fetch pipeline register.
  typedef struct packed {
    u32    raw_instr;
    addr_t pc;
  } fetch_data_t;

  typedef enum logic [1:0] {
    REQ,
    HOLD,
    FLUSH
  } fetch_state_t;

  // Instructions are word aligned; low address bits of a target are dropped.
  function automatic addr_t align_pc(input addr_t a);
    return a & ~addr_t'(3);
  endfunction

endpackage

// File: rtl/fetch_ctrl_pc_sel.sv
// Next-PC select: reset vector, redirect target, pending (flushed) target,
// sequential increment or hold. Purely combinational so the branch unit can
// reuse the same priority ordering.
module fetch_ctrl_pc_sel
  import fetch_ctrl_pkg::*;
#(
  parameter addr_t       RESET_PC    = PC_RESET,
  parameter int unsigned INSTR_BYTES = 4
) (
  input  logic        reset_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  input  logic        use_pend_i,
  input  logic [63:0] pend_pc_i,
  input  logic        advance_i,
  input  logic [63:0] pc_i,
  output logic [63:0] pc_o
);

  // Priority: reset > redirect > pending target > sequential > hold.
  always_comb begin
    pc_o = pc_i;
    if (reset_i) begin
      pc_o = RESET_PC;
    end else if (redirect_i) begin
      pc_o = align_pc(redirect_pc_i);
    end else if (use_pend_i) begin
      pc_o = pend_pc_i;
    end else if (advance_i) begin
      pc_o = pc_i + addr_t'(INSTR_BYTES);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the PC, runs the instruction bus handshake and
// presents one instruction at a time to the fetch->decode register.
// A redirect seen while a request is in flight cannot withdraw the request,
// so the controller parks the target in pend_pc_q (FLUSH) until the stale
// response arrives and is dropped.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter addr_t       RESET_PC    = PC_RESET,
  parameter int unsigned INSTR_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        ibus_req,
  output logic [63:0] ibus_addr,
  input  logic        ibus_data_ok,
  input  logic [31:0] ibus_data,
  output fetch_data_t dataF,
  output logic        instr_valid,
  output logic        stallI
);

  fetch_state_t state_q;
  addr_t        pc_q;
  addr_t        pc_d;
  addr_t        pend_pc_q;
  fetch_data_t  data_q;
  logic         req_q;

  logic in_req;
  logic in_hold;
  logic in_flush;
  logic take_redirect;
  logic use_pend;
  logic advance;

  assign in_req   = (state_q == REQ);
  assign in_hold  = (state_q == HOLD);
  assign in_flush = (state_q == FLUSH);

  // A redirect moves the PC immediately only when no request is left in
  // flight: from HOLD, or in the cycle the outstanding response returns.
  assign take_redirect = redirect & (in_hold | ((in_req | in_flush) & ibus_data_ok));
  assign use_pend      = in_flush & ibus_data_ok;
  assign advance       = in_hold & ~stall;

  fetch_ctrl_pc_sel #(
    .RESET_PC   (RESET_PC),
    .INSTR_BYTES(INSTR_BYTES)
  ) u_pc_sel (
    .reset_i      (reset),
    .redirect_i   (take_redirect),
    .redirect_pc_i(redirect_pc),
    .use_pend_i   (use_pend),
    .pend_pc_i    (pend_pc_q),
    .advance_i    (advance),
    .pc_i         (pc_q),
    .pc_o         (pc_d)
  );

  // Fetch FSM with registered bus request, payload and pending target.
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
    if (reset) begin
      state_q   <= REQ;
      pend_pc_q <= '0;
      data_q    <= '0;
      req_q     <= 1'b0;
    end else begin
      unique case (state_q)
        REQ: begin
          req_q <= 1'b1;
          if (ibus_data_ok) begin
            if (!redirect) begin
              data_q.raw_instr <= ibus_data;
              data_q.pc        <= pc_q;
              state_q          <= HOLD;
              req_q            <= 1'b0;
            end
          end else if (redirect) begin
            pend_pc_q <= align_pc(redirect_pc);
            state_q   <= FLUSH;
          end
        end
        HOLD: begin
          if (redirect || !stall) begin
            data_q.raw_instr <= '0;
            state_q          <= REQ;
            req_q            <= 1'b1;
          end
        end
        FLUSH: begin
          req_q <= 1'b1;
          if (ibus_data_ok) begin
            state_q <= REQ;
          end else if (redirect) begin
            pend_pc_q <= align_pc(redirect_pc);
          end
        end
        default: begin
          state_q <= REQ;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ibus_req    = req_q;
  assign ibus_addr   = pc_q;
  assign dataF       = data_q;
  assign instr_valid = in_hold;
  assign stallI      = ~in_hold;

endmodule
